// File: rtl/haz_pkg.sv
// haz_pkg: shared definitions for the EX-stage hazard controller.
//   haz_state_t : stall FSM states (S_RUN, S_MC_WAIT)
//   FWD_*       : EX operand forward-select encodings
//   fwd_sel()   : forwarding priority rule for one EX source operand
package haz_pkg;

    typedef enum logic {
        S_RUN     = 1'b0,
        S_MC_WAIT = 1'b1
    } haz_state_t;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_MEMWB = 2'd1;
    localparam logic [1:0] FWD_EXMEM = 2'd2;

    // The younger producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_exmem,
        input logic       we_exmem,
        input logic [4:0] rd_memwb,
        input logic       we_memwb
    );
        if (we_exmem && (rd_exmem != 5'd0) && (rd_exmem == rs)) return FWD_EXMEM;
        if (we_memwb && (rd_memwb != 5'd0) && (rd_memwb == rs)) return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/ex_hazard_ctrl_fwd_unit.sv
// fwd_unit: purely combinational EX operand forwarding selects.
// Ports:
//   rs1_IDEX, rs2_IDEX         : source registers of the instruction in EX
//   rd_EXMEM, RegWrite_EXMEM   : destination / write enable of the MEM instruction
//   rd_MEMWB, RegWrite_MEMWB   : destination / write enable of the WB instruction
//   ForwardA, ForwardB         : 0=register file, 1=MEM/WB data, 2=EX/MEM ALU result
module fwd_unit
    import haz_pkg::*;
(
    input  logic [4:0] rs1_IDEX,
    input  logic [4:0] rs2_IDEX,
    input  logic [4:0] rd_EXMEM,
    input  logic       RegWrite_EXMEM,
    input  logic [4:0] rd_MEMWB,
    input  logic       RegWrite_MEMWB,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB
);

    always_comb begin
        ForwardA = fwd_sel(rs1_IDEX, rd_EXMEM, RegWrite_EXMEM, rd_MEMWB, RegWrite_MEMWB);
        ForwardB = fwd_sel(rs2_IDEX, rd_EXMEM, RegWrite_EXMEM, rd_MEMWB, RegWrite_MEMWB);
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: hazard controller for the EX stage of the 5-stage RISC-V core.
// Forwarding selects, load-use bubbles, taken-branch flushes and a stall FSM
// that holds the pipeline while the multi-cycle EX unit (MUL/DIV) works.
// Parameters:
//   MC_TIMEOUT : max S_MC_WAIT cycles before aborting with mc_err
//   CNT_W      : performance counter width (only with HAZ_PERF_CNT_EN)
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   rs1_IFID, rs2_IFID                : sources of the instruction in ID
//   rs1_IDEX, rs2_IDEX, rd_IDEX       : sources/destination of the instruction in EX
//   memRead_IDEX, mc_req_IDEX         : EX instruction is a load / needs the MC unit
//   rd_EXMEM, RegWrite_EXMEM          : MEM-stage destination and write enable
//   branch_EXMEM, zero_EXMEM          : branch resolution in MEM (taken = both set)
//   rd_MEMWB, RegWrite_MEMWB          : WB-stage destination and write enable
//   mc_done                           : MC unit result valid (1-cycle pulse)
//   ForwardA, ForwardB                : EX operand selects
//   pc_write, ifid_write              : PC / IF-ID register enables
//   ifid_flush, idex_flush, exmem_flush : load a bubble into that register
//   idex_hold                         : hold the ID/EX register contents
//   pc_src                            : select branch target PC_EXMEM
//   mc_start                          : one-cycle launch pulse to the MC unit
//   mc_busy                           : FSM is in S_MC_WAIT (also the FSM state view)
//   mc_err                            : sticky timeout flag, cleared only by reset
// Optional: macro HAZ_PERF_CNT_EN adds stall_cycles, flush_events, mc_ops.
//
// MC unit handshake: mc_start is a single-cycle launch with no backpressure
// (the unit must accept it); mc_done is a single-cycle completion pulse that is
// only honoured while in S_MC_WAIT and ignored in S_RUN.
module ex_hazard_ctrl
    import haz_pkg::*;
#(
    parameter int MC_TIMEOUT = 64
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_IFID,
    input  logic [4:0] rs2_IFID,
    input  logic [4:0] rs1_IDEX,
    input  logic [4:0] rs2_IDEX,
    input  logic [4:0] rd_IDEX,
    input  logic       memRead_IDEX,
    input  logic       mc_req_IDEX,
    input  logic [4:0] rd_EXMEM,
    input  logic       RegWrite_EXMEM,
    input  logic       branch_EXMEM,
    input  logic       zero_EXMEM,
    input  logic [4:0] rd_MEMWB,
    input  logic       RegWrite_MEMWB,
    input  logic       mc_done,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       idex_hold,
    output logic       pc_src,
    output logic       mc_start,
    output logic       mc_busy,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] mc_ops,
`endif
    output logic       mc_err
);

    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(MC_TIMEOUT - 1);

    haz_state_t    state, state_nxt;
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic          skip_req, skip_nxt;
    logic          err_set;
    logic          taken, load_use, timed_out;

    fwd_unit u_fwd (
        .rs1_IDEX       (rs1_IDEX),
        .rs2_IDEX       (rs2_IDEX),
        .rd_EXMEM       (rd_EXMEM),
        .RegWrite_EXMEM (RegWrite_EXMEM),
        .rd_MEMWB       (rd_MEMWB),
        .RegWrite_MEMWB (RegWrite_MEMWB),
        .ForwardA       (ForwardA),
        .ForwardB       (ForwardB)
    );

    assign taken     = branch_EXMEM & zero_EXMEM;
    assign load_use  = memRead_IDEX && (rd_IDEX != 5'd0) &&
                       ((rd_IDEX == rs1_IFID) || (rd_IDEX == rs2_IFID));
    assign timed_out = (to_cnt == TO_LAST);

    always_comb begin
        state_nxt   = state;
        to_cnt_nxt  = to_cnt;
        skip_nxt    = 1'b0;
        err_set     = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        idex_hold   = 1'b0;
        pc_src      = 1'b0;
        mc_start    = 1'b0;
        mc_busy     = (state == S_MC_WAIT);

        if (taken) begin
            // Taken branch beats everything, including an in-flight MC op.
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_nxt   = S_RUN;
            to_cnt_nxt  = '0;
        end else begin
            case (state)
                S_RUN: begin
                    to_cnt_nxt = '0;
                    // skip_req masks the op that just completed, which is
                    // still visible on mc_req_IDEX for one cycle.
                    if (mc_req_IDEX && !skip_req) begin
                        mc_start  = 1'b1;
                        state_nxt = S_MC_WAIT;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                S_MC_WAIT: begin
                    // Completion or timeout releases the stall in this same
                    // cycle; done wins over a coincident timeout.
                    if (mc_done || timed_out) begin
                        state_nxt  = S_RUN;
                        to_cnt_nxt = '0;
                        skip_nxt   = 1'b1;
                        err_set    = !mc_done;
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_hold   = 1'b1;
                        exmem_flush = 1'b1;
                        to_cnt_nxt  = to_cnt + 1'b1;
                    end
                end
                default: state_nxt = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RUN;
            to_cnt   <= '0;
            skip_req <= 1'b0;
            mc_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            to_cnt   <= to_cnt_nxt;
            skip_req <= skip_nxt;
            if (err_set) mc_err <= 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
            mc_ops       <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
            if (taken && (flush_events != '1))     flush_events <= flush_events + 1'b1;
            if (mc_start && (mc_ops != '1))        mc_ops       <= mc_ops + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed and randomized bench for ex_hazard_ctrl against
// a cycle-level reference model of the hazard rules.
module tb_ex_hazard_ctrl;

    localparam int TO = 64;
    localparam longint CNT_MAX = 64'hFFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0] rs1_IFID, rs2_IFID, rs1_IDEX, rs2_IDEX, rd_IDEX, rd_EXMEM, rd_MEMWB;
    logic       memRead_IDEX, mc_req_IDEX, RegWrite_EXMEM, branch_EXMEM, zero_EXMEM;
    logic       RegWrite_MEMWB, mc_done;
    logic [1:0] ForwardA, ForwardB;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
    logic       idex_hold, pc_src, mc_start, mc_busy, mc_err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events, mc_ops;
`endif

    ex_hazard_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs1_IFID       (rs1_IFID),
        .rs2_IFID       (rs2_IFID),
        .rs1_IDEX       (rs1_IDEX),
        .rs2_IDEX       (rs2_IDEX),
        .rd_IDEX        (rd_IDEX),
        .memRead_IDEX   (memRead_IDEX),
        .mc_req_IDEX    (mc_req_IDEX),
        .rd_EXMEM       (rd_EXMEM),
        .RegWrite_EXMEM (RegWrite_EXMEM),
        .branch_EXMEM   (branch_EXMEM),
        .zero_EXMEM     (zero_EXMEM),
        .rd_MEMWB       (rd_MEMWB),
        .RegWrite_MEMWB (RegWrite_MEMWB),
        .mc_done        (mc_done),
        .ForwardA       (ForwardA),
        .ForwardB       (ForwardB),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_flush    (exmem_flush),
        .idex_hold      (idex_hold),
        .pc_src         (pc_src),
        .mc_start       (mc_start),
        .mc_busy        (mc_busy),
`ifdef HAZ_PERF_CNT_EN
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events),
        .mc_ops         (mc_ops),
`endif
        .mc_err         (mc_err)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [13:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Model state: whether an MC op is outstanding, how many wait cycles it
    // has spent, sticky error, and the one-cycle "don't relaunch" window.
    bit     m_busy, m_err, m_skip;
    int     m_waited;
    longint m_stall, m_flush, m_ops;

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_skip = 0; m_waited = 0;
        m_stall = 0; m_flush = 0; m_ops = 0;
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (RegWrite_EXMEM && rd_EXMEM != 0 && rd_EXMEM == rs) return 2'd2;
        if (RegWrite_MEMWB && rd_MEMWB != 0 && rd_MEMWB == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [13:0] pack_dut();
        return {ForwardA, ForwardB, pc_write, ifid_write, ifid_flush, idex_flush,
                exmem_flush, idex_hold, pc_src, mc_start, mc_busy, mc_err};
    endfunction

    // One cycle: called just after a rising edge with inputs already driven.
    task automatic step();
        logic e_pcw, e_ifw, e_iff, e_idf, e_exf, e_hold, e_src, e_start;
        bit   n_busy, n_err, n_skip;
        int   n_waited;
        #3;
        if (!rst_n) model_reset();
        e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_exf = 0; e_hold = 0; e_src = 0; e_start = 0;
        n_busy = m_busy; n_err = m_err; n_skip = 0; n_waited = m_waited;
        if (branch_EXMEM && zero_EXMEM) begin
            e_src = 1; e_iff = 1; e_idf = 1; e_exf = 1;
            n_busy = 0; n_waited = 0;
        end else if (m_busy) begin
            if (mc_done || m_waited == TO - 1) begin
                n_busy = 0; n_waited = 0; n_skip = 1;
                if (!mc_done) n_err = 1;
            end else begin
                e_pcw = 0; e_ifw = 0; e_hold = 1; e_exf = 1;
                n_waited = m_waited + 1;
            end
        end else if (mc_req_IDEX && !m_skip) begin
            e_start = 1; n_busy = 1; n_waited = 0;
        end else if (memRead_IDEX && rd_IDEX != 0 &&
                     (rd_IDEX == rs1_IFID || rd_IDEX == rs2_IFID)) begin
            e_pcw = 0; e_ifw = 0; e_idf = 1;
        end
        exp_q.push_back({fwd_ref(rs1_IDEX), fwd_ref(rs2_IDEX), e_pcw, e_ifw, e_iff, e_idf,
                         e_exf, e_hold, e_src, e_start, m_busy, m_err});
        check_eq("outs", {18'b0, pack_dut()}, {18'b0, exp_q.pop_front()});
`ifdef HAZ_PERF_CNT_EN
        check_eq("stall_cycles", stall_cycles, m_stall[31:0]);
        check_eq("flush_events", flush_events, m_flush[31:0]);
        check_eq("mc_ops", mc_ops, m_ops[31:0]);
`endif
        if (rst_n) begin
            if (!e_pcw && m_stall < CNT_MAX) m_stall++;
            if (branch_EXMEM && zero_EXMEM && m_flush < CNT_MAX) m_flush++;
            if (e_start && m_ops < CNT_MAX) m_ops++;
            m_busy = n_busy; m_err = n_err; m_skip = n_skip; m_waited = n_waited;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        rs1_IFID = 0; rs2_IFID = 0; rs1_IDEX = 0; rs2_IDEX = 0; rd_IDEX = 0;
        memRead_IDEX = 0; mc_req_IDEX = 0; rd_EXMEM = 0; RegWrite_EXMEM = 0;
        branch_EXMEM = 0; zero_EXMEM = 0; rd_MEMWB = 0; RegWrite_MEMWB = 0; mc_done = 0;
    endtask

    task automatic drive_random();
        rs1_IFID = 5'($urandom_range(0, 7)); rs2_IFID = 5'($urandom_range(0, 7));
        rs1_IDEX = 5'($urandom_range(0, 7)); rs2_IDEX = 5'($urandom_range(0, 7));
        rd_IDEX  = 5'($urandom_range(0, 7)); rd_EXMEM = 5'($urandom_range(0, 7));
        rd_MEMWB = 5'($urandom_range(0, 7));
        memRead_IDEX   = ($urandom_range(0, 2) == 0);
        mc_req_IDEX    = ($urandom_range(0, 6) == 0);
        RegWrite_EXMEM = 1'($urandom_range(0, 1));
        RegWrite_MEMWB = 1'($urandom_range(0, 1));
        branch_EXMEM   = ($urandom_range(0, 9) == 0);
        zero_EXMEM     = 1'($urandom_range(0, 1));
        mc_done        = ($urandom_range(0, 11) == 0);
    endtask

    task automatic pulse_reset();
        rst_n = 0; step();
        rst_n = 1; step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive_idle();
        model_reset();
        rst_n = 0;
        @(posedge clk);
        #1;
        step();
        step();
        rst_n = 1;
        step();

        // Forwarding priority and x0.
        rd_EXMEM = 5; RegWrite_EXMEM = 1; rd_MEMWB = 5; RegWrite_MEMWB = 1;
        rs1_IDEX = 5; rs2_IDEX = 5; step();
        rd_EXMEM = 0; step();
        rs1_IDEX = 0; step();
        rs2_IDEX = 6; rd_EXMEM = 6; step();
        RegWrite_EXMEM = 0; RegWrite_MEMWB = 0; step();
        drive_idle();

        // Load-use: load into x7, consumer reads x7 as rs2.
        memRead_IDEX = 1; rd_IDEX = 7; rs2_IFID = 7; step();
        memRead_IDEX = 0; rd_IDEX = 0; step();
        memRead_IDEX = 1; rd_IDEX = 0; rs1_IFID = 0; step();   // x0 load never stalls
        drive_idle();

        // Taken vs not-taken branch.
        branch_EXMEM = 1; zero_EXMEM = 1; step();
        zero_EXMEM = 0; step();
        drive_idle();

        // MC op completing 10 cycles after launch, no relaunch.
        mc_req_IDEX = 1; step();
        for (int i = 0; i < 9; i++) step();
        mc_done = 1; step();
        mc_done = 0; step();
        mc_req_IDEX = 0; step();

        // MC op timing out.
        mc_req_IDEX = 1; step();
        for (int i = 0; i < TO; i++) step();
        step();
        mc_req_IDEX = 0;
        for (int i = 0; i < 3; i++) step();
        pulse_reset();

        // Done coincident with timeout: no error.
        mc_req_IDEX = 1; step();
        for (int i = 0; i < TO - 1; i++) step();
        mc_done = 1; step();
        mc_done = 0; mc_req_IDEX = 0; step();
        pulse_reset();

        // Branch on the 3rd wait cycle, late mc_done ignored.
        mc_req_IDEX = 1; step();
        step(); step();
        branch_EXMEM = 1; zero_EXMEM = 1; step();
        drive_idle(); mc_done = 1; step();
        mc_done = 0; step();

        // Reset in the middle of a wait.
        mc_req_IDEX = 1; step();
        step(); step();
        rst_n = 0; step();
        rst_n = 1; mc_req_IDEX = 0; step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            if ($urandom_range(0, 999) == 0) rst_n = 0;
            else rst_n = 1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
